// File: rtl/ex_stage_pkg.sv
// Shared types for the EX stage: bus layouts, operation codes, stall encoding.
package ex_stage_pkg;

   localparam int   STALL_W      = 6;
   localparam int   ID_TO_EX_WD  = 149;
   localparam int   EX_TO_MEM_WD = 80;
   localparam logic STOP         = 1'b1;
   localparam logic NOSTOP       = 1'b0;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_NOR,
      ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS
   } alu_op_e;

   typedef enum logic [3:0] {
      HILO_NONE, HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU,
      HILO_MFHI, HILO_MFLO, HILO_MTHI, HILO_MTLO
   } hilo_op_e;

   typedef enum logic [3:0] {
      MEM_NONE   = 4'b0000,
      MEM_BYTE_S = 4'b0001,
      MEM_BYTE_U = 4'b0010,
      MEM_HALF_S = 4'b0011,
      MEM_HALF_U = 4'b0100,
      MEM_WORD   = 4'b1111
   } mem_op_e;

   typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

   typedef struct packed {
      logic [31:0] pc;
      alu_op_e     alu_op;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] store_data;
      hilo_op_e    hilo_op;
      mem_op_e     mem_op;
      logic        data_ram_en;
      logic        is_store;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
   } id_to_ex_t;

   typedef struct packed {
      logic [3:0]  readen;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;

   function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// EX stage bundle: stall/decoded-instruction inputs, MEM bus, forwarding and data-SRAM request.
interface ex_stage_if;
   import ex_stage_pkg::*;

   logic [STALL_W-1:0] stall;
   id_to_ex_t          id_to_ex_bus;
   ex_to_mem_t         ex_to_mem_bus;
   logic [37:0]        ex_to_id;
   logic               ex_is_load;
   logic               stallreq_for_ex;
   logic               data_sram_en;
   logic [3:0]         data_sram_wen;
   logic [31:0]        data_sram_addr;
   logic [31:0]        data_sram_wdata;

   modport master (
      output stall, id_to_ex_bus,
      input  ex_to_mem_bus, ex_to_id, ex_is_load, stallreq_for_ex,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );

   modport slave (
      input  stall, id_to_ex_bus,
      output ex_to_mem_bus, ex_to_id, ex_is_load, stallreq_for_ex,
             data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
   );

endinterface

// File: rtl/ex_stage_div_unit.sv
// 32-step restoring divider, 34 cycles start-to-release; holds DONE until i_ack,
// requests a pipeline stall from start until the quotient is ready.
module div_unit
   import ex_stage_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_signed,
   input  logic        i_ack,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   output logic        o_stallreq,
   output logic        o_done,
   output logic [31:0] o_quot,
   output logic [31:0] o_rem
);
   div_state_e  r_state, w_state_nxt;
   logic [4:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_divisor;
   logic        r_neg_q, r_neg_r;
   logic [64:0] w_shift;
   logic [32:0] w_diff;
   logic [63:0] w_step;

   // r_acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
   always_comb begin
      w_shift = {r_acc, 1'b0};
      w_diff  = w_shift[64:32] - {1'b0, r_divisor};
      w_step  = w_shift[63:0];
      if (!w_diff[32]) begin
         w_step = {w_diff[31:0], w_shift[31:1], 1'b1};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      o_stallreq  = 1'b0;
      case (r_state)
         DIV_IDLE: begin
            if (i_start) begin
               w_state_nxt = DIV_BUSY;
               o_stallreq  = 1'b1;
            end
         end
         DIV_BUSY: begin
            o_stallreq = 1'b1;
            if (r_cnt == 5'd31) w_state_nxt = DIV_DONE;
         end
         DIV_DONE: begin
            if (i_ack) w_state_nxt = DIV_IDLE;
         end
         default: w_state_nxt = DIV_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= DIV_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_divisor <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == DIV_IDLE && i_start) begin
            r_acc     <= {32'd0, mag32(i_dividend, i_signed)};
            r_divisor <= mag32(i_divisor, i_signed);
            r_neg_q   <= i_signed & (i_dividend[31] ^ i_divisor[31]);
            r_neg_r   <= i_signed & i_dividend[31];
            r_cnt     <= '0;
         end else if (r_state == DIV_BUSY) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
         end
      end
   end

   assign o_done = (r_state == DIV_DONE);
   assign o_quot = r_neg_q ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
   assign o_rem  = r_neg_r ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID->EX register, ALU, HI/LO, load/store lanes; results one cycle after load.
// Stalls the pipeline via stallreq_for_ex while a divide is running; honours per-stage stall.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   ex_stage_if.slave  io_bus
);
   id_to_ex_t   r_ex;
   logic [31:0] r_hi, r_lo;
   logic [31:0] w_alu, w_result, w_wdata, w_quot, w_rem;
   logic [63:0] w_prod_s, w_prod_u;
   logic [3:0]  w_wen;
   logic        w_load, w_store, w_is_div, w_div_done, w_div_stallreq, w_leave;
   ex_to_mem_t  w_mem;

   assign w_leave = (io_bus.stall[2] == NOSTOP);

   always_ff @(posedge i_clk) begin
      if (i_rst)                                             r_ex <= '0;
      else if (io_bus.stall[2] == STOP && io_bus.stall[3] == NOSTOP) r_ex <= '0;
      else if (w_leave)                                      r_ex <= io_bus.id_to_ex_bus;
   end

   always_comb begin
      w_alu = '0;
      case (r_ex.alu_op)
         ALU_ADD:  w_alu = r_ex.src1 + r_ex.src2;
         ALU_SUB:  w_alu = r_ex.src1 - r_ex.src2;
         ALU_SLT:  w_alu = {31'd0, $signed(r_ex.src1) < $signed(r_ex.src2)};
         ALU_SLTU: w_alu = {31'd0, r_ex.src1 < r_ex.src2};
         ALU_AND:  w_alu = r_ex.src1 & r_ex.src2;
         ALU_OR:   w_alu = r_ex.src1 | r_ex.src2;
         ALU_NOR:  w_alu = ~(r_ex.src1 | r_ex.src2);
         ALU_XOR:  w_alu = r_ex.src1 ^ r_ex.src2;
         ALU_SLL:  w_alu = r_ex.src2 << r_ex.src1[4:0];
         ALU_SRL:  w_alu = r_ex.src2 >> r_ex.src1[4:0];
         ALU_SRA:  w_alu = $unsigned($signed(r_ex.src2) >>> r_ex.src1[4:0]);
         ALU_LUI:  w_alu = {r_ex.src2[15:0], 16'd0};
         ALU_PASS: w_alu = r_ex.src1;
         default:  w_alu = '0;
      endcase
   end

   always_comb begin
      w_result = w_alu;
      if (r_ex.hilo_op == HILO_MFHI)      w_result = r_hi;
      else if (r_ex.hilo_op == HILO_MFLO) w_result = r_lo;
   end

   // Low 64 bits of a product of sign-extended operands equal the signed product
   assign w_prod_s = {{32{r_ex.src1[31]}}, r_ex.src1} * {{32{r_ex.src2[31]}}, r_ex.src2};
   assign w_prod_u = {32'd0, r_ex.src1} * {32'd0, r_ex.src2};
   assign w_is_div = (r_ex.hilo_op == HILO_DIV) || (r_ex.hilo_op == HILO_DIVU);

   div_unit u_div (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_start    (w_is_div),
      .i_signed   (r_ex.hilo_op == HILO_DIV),
      .i_ack      (w_leave),
      .i_dividend (r_ex.src1),
      .i_divisor  (r_ex.src2),
      .o_stallreq (w_div_stallreq),
      .o_done     (w_div_done),
      .o_quot     (w_quot),
      .o_rem      (w_rem)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (w_leave) begin
         case (r_ex.hilo_op)
            HILO_MULT:  {r_hi, r_lo} <= w_prod_s;
            HILO_MULTU: {r_hi, r_lo} <= w_prod_u;
            HILO_DIV, HILO_DIVU: begin
               if (w_div_done) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end
            end
            HILO_MTHI:  r_hi <= r_ex.src1;
            HILO_MTLO:  r_lo <= r_ex.src1;
            default: ;
         endcase
      end
   end

   assign w_load  = r_ex.data_ram_en & ~r_ex.is_store;
   assign w_store = r_ex.data_ram_en &  r_ex.is_store;

   always_comb begin
      w_wen   = 4'b0000;
      w_wdata = '0;
      if (w_store) begin
         case (r_ex.mem_op)
            MEM_WORD: begin
               w_wen   = 4'b1111;
               w_wdata = r_ex.store_data;
            end
            MEM_BYTE_S, MEM_BYTE_U: begin
               w_wen   = 4'b0001 << w_result[1:0];
               w_wdata = {4{r_ex.store_data[7:0]}};
            end
            MEM_HALF_S, MEM_HALF_U: begin
               w_wen   = w_result[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{r_ex.store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_mem              = '0;
      w_mem.readen       = w_load ? r_ex.mem_op : 4'b0000;
      w_mem.pc           = r_ex.pc;
      w_mem.data_ram_en  = r_ex.data_ram_en;
      w_mem.data_ram_wen = w_wen;
      w_mem.sel_rf_res   = r_ex.sel_rf_res;
      w_mem.rf_we        = r_ex.rf_we;
      w_mem.rf_waddr     = r_ex.rf_waddr;
      w_mem.ex_result    = w_result;
   end

   assign io_bus.ex_to_mem_bus   = w_mem;
   assign io_bus.ex_to_id        = {r_ex.rf_we, r_ex.rf_waddr, w_result};
   assign io_bus.ex_is_load      = w_load;
   assign io_bus.stallreq_for_ex = w_div_stallreq;
   assign io_bus.data_sram_en    = r_ex.data_ram_en;
   assign io_bus.data_sram_wen   = w_wen;
   assign io_bus.data_sram_addr  = w_result;
   assign io_bus.data_sram_wdata = w_wdata;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected MEM-bus words queued at issue, popped one cycle later.
module tb_ex_stage;
   import ex_stage_pkg::*;

   localparam logic [5:0] STALL_NONE   = 6'b000000;
   localparam logic [5:0] STALL_EX     = 6'b001111;
   localparam logic [5:0] STALL_BUBBLE = 6'b000111;

   logic        clk = 1'b0;
   logic        rst;
   int          vectors = 0;
   int          miscompares = 0;
   int          cnt;
   logic [31:0] pc_ctr = 32'h0000_3000;
   ex_to_mem_t  exp_q [$];
   ex_to_mem_t  held;

   alu_op_e     t_op  [13] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_NOR,
                               ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASS};
   logic [31:0] t_s1  [13] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_FFFF,
                               32'hF0F0_0000, 32'h0F0F_0000, 32'hFFFF_0000, 32'd4, 32'h24, 32'd4,
                               32'd99, 32'hBFC0_0008};
   logic [31:0] t_s2  [13] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'h0FF0_0F0F, 32'h000F_0F0F,
                               32'h0000_0F0F, 32'h0F0F_0F0F, 32'h0000_00F1, 32'h8000_0000,
                               32'h8000_0000, 32'h0000_1234, 32'd5};
   logic [31:0] t_res [13] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'h00F0_0F0F,
                               32'hF0FF_0F0F, 32'hF0F0_F0F0, 32'hF0F0_0F0F, 32'h0000_0F10,
                               32'h0800_0000, 32'hF800_0000, 32'h1234_0000, 32'hBFC0_0008};

   ex_stage_if bus ();

   ex_stage dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic id_to_ex_t mk_ins(input alu_op_e alu, input hilo_op_e hilo, input mem_op_e mop,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [31:0] sd, input logic ram_en, input logic st,
                                        input logic we, input logic [4:0] wa);
      id_to_ex_t t;
      t             = '0;
      t.alu_op      = alu;
      t.hilo_op     = hilo;
      t.mem_op      = mop;
      t.src1        = s1;
      t.src2        = s2;
      t.store_data  = sd;
      t.data_ram_en = ram_en;
      t.is_store    = st;
      t.sel_rf_res  = ram_en & ~st;
      t.rf_we       = we;
      t.rf_waddr    = wa;
      return t;
   endfunction

   function automatic ex_to_mem_t mk_exp(input logic [3:0] rd, input logic ram_en, input logic [3:0] wen,
                                         input logic sel, input logic we, input logic [4:0] wa,
                                         input logic [31:0] res);
      ex_to_mem_t e;
      e              = '0;
      e.readen       = rd;
      e.data_ram_en  = ram_en;
      e.data_ram_wen = wen;
      e.sel_rf_res   = sel;
      e.rf_we        = we;
      e.rf_waddr     = wa;
      e.ex_result    = res;
      return e;
   endfunction

   // Drive one instruction with no stall, then compare the MEM bus one edge later
   task automatic issue(input string tag, input id_to_ex_t ins, input ex_to_mem_t exp);
      ex_to_mem_t want;
      ins.pc = pc_ctr;
      exp.pc = pc_ctr;
      pc_ctr = pc_ctr + 32'd4;
      bus.id_to_ex_bus = ins;
      bus.stall        = STALL_NONE;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      bus.id_to_ex_bus = '0;
      want = exp_q.pop_front();
      check(tag, 80'(bus.ex_to_mem_bus), 80'(want));
   endtask

   task automatic read_hilo(input string tag, input hilo_op_e op, input logic [31:0] want);
      issue(tag, mk_ins(ALU_ADD, op, MEM_NONE, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd9, want));
   endtask

   task automatic run_div(input string tag, input hilo_op_e op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] want_lo, input logic [31:0] want_hi);
      issue(tag, mk_ins(ALU_PASS, op, MEM_NONE, s1, s2, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, s1));
      cnt = 0;
      while (bus.stallreq_for_ex === 1'b1 && cnt < 100) begin
         bus.stall = STALL_EX;
         cnt++;
         @(posedge clk);
         #1;
      end
      check({tag, "_stall_cycles"}, 80'(cnt), 80'd33);
      read_hilo({tag, "_lo"}, HILO_MFLO, want_lo);
      read_hilo({tag, "_hi"}, HILO_MFHI, want_hi);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst              = 1'b1;
      bus.stall        = STALL_NONE;
      bus.id_to_ex_bus = mk_ins(ALU_ADD, HILO_MULT, MEM_WORD, 32'h1, 32'h2, 32'h3, 1'b1, 1'b0, 1'b1, 5'd7);
      repeat (3) @(posedge clk);
      #1;
      check("reset_mem_bus", 80'(bus.ex_to_mem_bus), 80'd0);
      check("reset_ex_to_id", 80'(bus.ex_to_id), 80'd0);
      check("reset_sram", 80'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr, bus.data_sram_wdata}), 80'd0);
      check("reset_flags", 80'({bus.ex_is_load, bus.stallreq_for_ex}), 80'd0);
      rst              = 1'b0;
      bus.id_to_ex_bus = '0;
      read_hilo("reset_hi", HILO_MFHI, 32'd0);
      read_hilo("reset_lo", HILO_MFLO, 32'd0);

      issue("add_5_7", mk_ins(ALU_ADD, HILO_NONE, MEM_NONE, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd3, 32'd12));
      check("add_fwd", 80'(bus.ex_to_id), 80'({1'b1, 5'd3, 32'd12}));

      for (int i = 0; i < 13; i++) begin
         issue($sformatf("alu_%0d", i),
               mk_ins(t_op[i], HILO_NONE, MEM_NONE, t_s1[i], t_s2[i], 32'd0, 1'b0, 1'b0, 1'b1, 5'(i + 1)),
               mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'(i + 1), t_res[i]));
      end

      issue("sb_1002", mk_ins(ALU_ADD, HILO_NONE, MEM_BYTE_S, 32'h1000, 32'd2, 32'h0000_00AB, 1'b1, 1'b1, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b1, 4'b0100, 1'b0, 1'b0, 5'd0, 32'h0000_1002));
      check("sb_sram", 80'({bus.data_sram_en, bus.data_sram_wen, bus.data_sram_addr, bus.data_sram_wdata}),
            80'({1'b1, 4'b0100, 32'h0000_1002, 32'hABAB_ABAB}));
      issue("sb_1003", mk_ins(ALU_ADD, HILO_NONE, MEM_BYTE_U, 32'h1000, 32'd3, 32'h1234_565A, 1'b1, 1'b1, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b1, 4'b1000, 1'b0, 1'b0, 5'd0, 32'h0000_1003));
      check("sb3_wdata", 80'(bus.data_sram_wdata), 80'(32'h5A5A_5A5A));
      issue("sh_1002", mk_ins(ALU_ADD, HILO_NONE, MEM_HALF_U, 32'h1000, 32'd2, 32'h1234_CDEF, 1'b1, 1'b1, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b1, 4'b1100, 1'b0, 1'b0, 5'd0, 32'h0000_1002));
      check("sh_wdata", 80'(bus.data_sram_wdata), 80'(32'hCDEF_CDEF));
      issue("sw_2000", mk_ins(ALU_ADD, HILO_NONE, MEM_WORD, 32'h2000, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h0000_2000));
      check("sw_wdata", 80'(bus.data_sram_wdata), 80'(32'hDEAD_BEEF));
      issue("lh_2002", mk_ins(ALU_ADD, HILO_NONE, MEM_HALF_S, 32'h2000, 32'd2, 32'd0, 1'b1, 1'b0, 1'b1, 5'd8),
            mk_exp(4'b0011, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd8, 32'h0000_2002));
      check("lh_is_load", 80'({bus.ex_is_load, bus.data_sram_en, bus.data_sram_wen}), 80'({1'b1, 1'b1, 4'b0000}));

      issue("multu", mk_ins(ALU_PASS, HILO_MULTU, MEM_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF));
      read_hilo("multu_hi", HILO_MFHI, 32'hFFFF_FFFE);
      read_hilo("multu_lo", HILO_MFLO, 32'h0000_0001);
      issue("mult", mk_ins(ALU_PASS, HILO_MULT, MEM_NONE, 32'hFFFF_FFFD, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFD));
      read_hilo("mult_lo", HILO_MFLO, 32'hFFFF_FFF4);
      read_hilo("mult_hi", HILO_MFHI, 32'hFFFF_FFFF);
      issue("mthi", mk_ins(ALU_PASS, HILO_MTHI, MEM_NONE, 32'h1111_2222, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h1111_2222));
      issue("mtlo", mk_ins(ALU_PASS, HILO_MTLO, MEM_NONE, 32'h3333_4444, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'h3333_4444));
      read_hilo("mt_hi", HILO_MFHI, 32'h1111_2222);
      read_hilo("mt_lo", HILO_MFLO, 32'h3333_4444);

      run_div("div_m7_2", HILO_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("div_7_m2", HILO_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_div("divu_by0", HILO_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100);

      // Hold keeps the EX contents; a bubble empties them
      issue("pre_hold", mk_ins(ALU_ADD, HILO_NONE, MEM_NONE, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd4, 32'd3));
      held    = mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 5'd4, 32'd3);
      held.pc = pc_ctr - 32'd4;
      exp_q.push_back(held);
      bus.stall        = STALL_EX;
      bus.id_to_ex_bus = mk_ins(ALU_SUB, HILO_NONE, MEM_NONE, 32'd9, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
      @(posedge clk);
      #1;
      check("hold", 80'(bus.ex_to_mem_bus), 80'(exp_q.pop_front()));
      exp_q.push_back('0);
      bus.stall = STALL_BUBBLE;
      @(posedge clk);
      #1;
      check("bubble", 80'(bus.ex_to_mem_bus), 80'(exp_q.pop_front()));
      check("bubble_fwd", 80'(bus.ex_to_id), 80'd0);

      issue("div_abort", mk_ins(ALU_PASS, HILO_DIV, MEM_NONE, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0),
            mk_exp(4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 5'd0, 32'd100));
      bus.stall = STALL_EX;
      repeat (11) @(posedge clk);
      #1;
      check("busy_stallreq", 80'(bus.stallreq_for_ex), 80'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_stallreq", 80'(bus.stallreq_for_ex), 80'd0);
      check("abort_mem_bus", 80'(bus.ex_to_mem_bus), 80'd0);
      read_hilo("abort_hi", HILO_MFHI, 32'd0);
      read_hilo("abort_lo", HILO_MFLO, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline; sits between ID and MEM and produces the EX→MEM bus that MEM consumes. Contains the ID→EX pipeline register, the ALU, and load/store address and byte-lane generation. It also holds the architectural HI/LO pair and a 32-cycle iterative divider, which holds the pipeline through a stall request. Also drives the data-SRAM request and the EX forwarding path back to ID.

## Interface
- ID_TO_EX_WD, 149: {pc[148:117], alu_op[116:113], src1[112:81], src2[80:49], store_data[48:17], hilo_op[16:13], mem_op[12:9], data_ram_en[8], is_store[7], sel_rf_res[6], rf_we[5], rf_waddr[4:0]}
- EX_TO_MEM_WD, 80: {readen[79:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- Ports:
  - clk  in  1  clock
  - rst  in  1  synchronous, active-high reset
  - stall  in  StallBus(6)  per-stage stop; Stop=1
  - id_to_ex_bus  in  ID_TO_EX_WD  decoded instruction
  - ex_to_mem_bus  out  EX_TO_MEM_WD  to MEM
  - ex_to_id  out  38  {rf_we, rf_waddr, ex_result} forwarding
  - ex_is_load  out  1  data_ram_en & !is_store, for load-use stall in ID
  - stallreq_for_ex  out  1  divider busy
  - data_sram_en  out  1;  data_sram_wen  out  4;  data_sram_addr  out  32;  data_sram_wdata  out  32

## Operation
- Pipeline register, priority: rst → 0; stall[2]=Stop & stall[3]=NoStop → 0 (bubble); stall[2]=NoStop → load; else hold.
- alu_op: ADD, SUB, SLT, SLTU, AND, OR, NOR, XOR, SLL, SRL, SRA (shamt = src1[4:0], operand src2), LUI (src2<<16), PASS (src1; used for link). No overflow trap.
- ex_result = HI when hilo_op=MFHI, LO when MFLO, else ALU result. ALU computes address for memory ops.
- mem_op codes: 1111 word, 0001 byte signed, 0010 byte unsigned, 0011 half signed, 0100 half unsigned.
- Loads: readen=mem_op, wen=0000. Stores: readen=0000; word → wen 1111, wdata=store_data; byte → wen=1<<addr[1:0], wdata={4{store_data[7:0]}}; half → wen 0011 (addr[1]=0) or 1100, wdata={2{store_data[15:0]}}.
- data_sram_addr = ex_result; data_sram_en = data_ram_en; all SRAM outputs combinational from the pipeline register.
- hilo_op: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI (HI←src1), MTLO (LO←src1). MULT/MULTU single-cycle 64-bit product, {HI,LO}←product.
- HI/LO commit on the edge where stall[2]=NoStop (instruction leaves EX); stall repeats are idempotent.
- Divider FSM IDLE→BUSY→DONE. IDLE with DIV/DIVU in EX: latch |src1|,|src2| (signed) or raw, enter BUSY, count=0. BUSY: one restoring step per cycle, count 0..31; at count=31 → DONE. DONE: LO=quotient, HI=remainder (sign fix: quotient negative iff signs differ, remainder takes dividend sign); commits per rule above; DONE→IDLE on stall[2]=NoStop.
- stallreq_for_ex = (IDLE & div op) | BUSY; low in DONE.
- Divide by zero: runs normally; unsigned gives LO=FFFFFFFF, HI=dividend; no exception.

## Timing
- Reset: pipeline register, HI, LO = 0; FSM IDLE; all outputs 0.
- ALU/mult/memory: zero added latency; result on ex_to_mem_bus the cycle after the ID load edge.
- DIV: 34 cycles in EX (1 IDLE-start + 32 BUSY + 1 DONE); stallreq asserted for the first 33.
- rst during BUSY aborts: FSM IDLE, HI/LO=0, stallreq drops next cycle.
- MFHI directly after MULT/DIV sees new value (committed on leaving edge).

## Structure
- ID_TO_EX_WD, EX_TO_MEM_WD, alu_op, hilo_op, mem_op codes, Stop/NoStop in lib/defines.vh.
- One sub-module: div_unit (FSM, counter, 64-bit shift remainder, signed fixup; start/signed/done handshake).

## Test plan
- ADD src1=5, src2=7, rf_waddr=3 → next cycle ex_result=12, ex_to_id={1,3,12}.
- SB store_data=0x000000AB, addr 0x1002 → wen 0100, wdata 0xABABABAB, readen 0000.
- LH addr 0x2002 → readen 0011, wen 0000, ex_is_load=1.
- DIV src1=-7, src2=2 → stallreq 33 cycles, then MFLO=FFFFFFFD, MFHI=FFFFFFFF.
- MULTU FFFFFFFF×FFFFFFFF → HI=FFFFFFFE, LO=00000001.
- stall[2]=1, stall[3]=0 for one cycle → MEM bus all-zero bubble; rst at BUSY count 10 → FSM IDLE, HI/LO=0.
